// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
//   Shared definitions for the dual-lane data-memory arbiter:
//     - state_t   : arbiter FSM encoding (IDLE/L1_WAIT/L2_WAIT/DONE)
//     - AW_DEF    : default address width
//     - DW_DEF    : default data width
//     - CNT_W_DEF : default conflict-counter width
//   Optional feature macro used by the arbiter: DMEM_ARB_STATS_EN
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

  localparam int AW_DEF    = 32;
  localparam int DW_DEF    = 32;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_L1_WAIT = 2'd1,
    ST_L2_WAIT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage : dmem_arb_pkg

// File: rtl/dmem_arb_stats.sv
// -----------------------------------------------------------------------------
// dmem_arb_stats
//   Saturating event counter used to count dual-lane (conflict) memory steps.
//   Only instantiated when DMEM_ARB_STATS_EN is defined.
// Ports:
//   clk    in   1      system clock, rising edge
//   reset  in   1      asynchronous, active-low reset (clears the count)
//   i_inc  in   1      count one event this cycle
//   o_cnt  out  CNT_W  current count, sticks at all-ones
// -----------------------------------------------------------------------------
module dmem_arb_stats
  import dmem_arb_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  // Hold at all-ones instead of wrapping so a long run never reads as "few".
  always_comb begin
    w_cnt_next = r_cnt;
    if (i_inc && (r_cnt != CNT_MAX)) begin
      w_cnt_next = r_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  assign o_cnt = r_cnt;

endmodule : dmem_arb_stats

// File: rtl/dmem_dual_lane_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_dual_lane_arbiter
//   Shares one single-ported data memory between the two issue lanes at the
//   EX/MEM stage. Lane 1 is older in program order and is always served first.
//   Each pipeline step performs 0, 1 or 2 memory transactions over a req/ack
//   handshake; a global stall freezes the pipeline latches until all accesses
//   of the step have completed.
//
// Optional feature: define DMEM_ARB_STATS_EN to enable the saturating
//   conflict counter (conflict_cnt). Without it conflict_cnt is tied to 0.
//
// Ports:
//   clk                 in   1      system clock, rising edge
//   reset               in   1      asynchronous, active-low reset
//   l1_req/l1_we        in   1/1    lane 1 access request / write(1) read(0)
//   l1_addr/l1_wdata    in   AW/DW  lane 1 byte address / store data
//   l2_req/l2_we        in   1/1    lane 2 access request / write(1) read(0)
//   l2_addr/l2_wdata    in   AW/DW  lane 2 byte address / store data
//   l1_rdata/l2_rdata   out  DW     per-lane load data, valid in DONE, then held
//   stall               out  1      freeze PC and all pipeline latches
//   mem_req/mem_we      out  1/1    registered memory request / write enable
//   mem_addr/mem_wdata  out  AW/DW  registered memory address / write data
//   mem_ack             in   1      one-cycle completion pulse
//   mem_rdata           in   DW     memory read data, valid with mem_ack
//   conflict_cnt        out  CNT_W  dual-lane step count (stats build only)
// -----------------------------------------------------------------------------
module dmem_dual_lane_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             l1_req,
  input  logic             l1_we,
  input  logic [AW-1:0]    l1_addr,
  input  logic [DW-1:0]    l1_wdata,
  input  logic             l2_req,
  input  logic             l2_we,
  input  logic [AW-1:0]    l2_addr,
  input  logic [DW-1:0]    l2_wdata,
  output logic [DW-1:0]    l1_rdata,
  output logic [DW-1:0]    l2_rdata,
  output logic             stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic             mem_ack,
  input  logic [DW-1:0]    mem_rdata,
  output logic [CNT_W-1:0] conflict_cnt
);

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t          r_state;
  logic            r_mem_req;
  logic            r_mem_we;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_wdata;
  logic [DW-1:0]   r_l1_rdata;
  logic [DW-1:0]   r_l2_rdata;

  // Lane 2 snapshot taken in IDLE when lane 1 goes first; r_l2_pend says the
  // snapshot still has to be issued once lane 1 completes.
  logic            r_l2_pend;
  logic            r_l2_we;
  logic [AW-1:0]   r_l2_addr;
  logic [DW-1:0]   r_l2_wdata;

  state_t          w_state_next;
  logic            w_mem_req_next;
  logic            w_mem_we_next;
  logic [AW-1:0]   w_mem_addr_next;
  logic [DW-1:0]   w_mem_wdata_next;
  logic [DW-1:0]   w_l1_rdata_next;
  logic [DW-1:0]   w_l2_rdata_next;
  logic            w_l2_pend_next;
  logic            w_l2_we_next;
  logic [AW-1:0]   w_l2_addr_next;
  logic [DW-1:0]   w_l2_wdata_next;

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next     = r_state;
    w_mem_req_next   = r_mem_req;
    w_mem_we_next    = r_mem_we;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    w_l1_rdata_next  = r_l1_rdata;
    w_l2_rdata_next  = r_l2_rdata;
    w_l2_pend_next   = r_l2_pend;
    w_l2_we_next     = r_l2_we;
    w_l2_addr_next   = r_l2_addr;
    w_l2_wdata_next  = r_l2_wdata;

    unique case (r_state)
      ST_IDLE: begin
        if (l1_req) begin
          // Lane 1 goes out now; lane 2 is frozen here so that the stalled
          // EX/MEM contents and the issued request can never disagree.
          w_state_next     = ST_L1_WAIT;
          w_mem_req_next   = 1'b1;
          w_mem_we_next    = l1_we;
          w_mem_addr_next  = l1_addr;
          w_mem_wdata_next = l1_wdata;
          w_l2_pend_next   = l2_req;
          w_l2_we_next     = l2_we;
          w_l2_addr_next   = l2_addr;
          w_l2_wdata_next  = l2_wdata;
        end else if (l2_req) begin
          // Lane 2 alone: issue directly, nothing left pending.
          w_state_next     = ST_L2_WAIT;
          w_mem_req_next   = 1'b1;
          w_mem_we_next    = l2_we;
          w_mem_addr_next  = l2_addr;
          w_mem_wdata_next = l2_wdata;
          w_l2_pend_next   = 1'b0;
        end
      end

      ST_L1_WAIT: begin
        if (mem_ack) begin
          w_mem_req_next = 1'b0;
          if (!r_mem_we) begin
            w_l1_rdata_next = mem_rdata;
          end
          if (r_l2_pend) begin
            // Load the lane 2 command now but keep mem_req low for one
            // cycle; L2_WAIT raises it on its first cycle.
            w_state_next     = ST_L2_WAIT;
            w_mem_we_next    = r_l2_we;
            w_mem_addr_next  = r_l2_addr;
            w_mem_wdata_next = r_l2_wdata;
            w_l2_pend_next   = 1'b0;
          end else begin
            w_state_next = ST_DONE;
          end
        end
      end

      ST_L2_WAIT: begin
        if (!r_mem_req) begin
          // Gap cycle after lane 1; an ack here belongs to nothing.
          w_mem_req_next = 1'b1;
        end else if (mem_ack) begin
          w_mem_req_next = 1'b0;
          if (!r_mem_we) begin
            w_l2_rdata_next = mem_rdata;
          end
          w_state_next = ST_DONE;
        end
      end

      ST_DONE: begin
        // Pipeline latches advance this cycle; lane inputs are stale.
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next   = ST_IDLE;
        w_mem_req_next = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_l1_rdata  <= '0;
      r_l2_rdata  <= '0;
      r_l2_pend   <= 1'b0;
      r_l2_we     <= 1'b0;
      r_l2_addr   <= '0;
      r_l2_wdata  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_mem_req   <= w_mem_req_next;
      r_mem_we    <= w_mem_we_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
      r_l1_rdata  <= w_l1_rdata_next;
      r_l2_rdata  <= w_l2_rdata_next;
      r_l2_pend   <= w_l2_pend_next;
      r_l2_we     <= w_l2_we_next;
      r_l2_addr   <= w_l2_addr_next;
      r_l2_wdata  <= w_l2_wdata_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic w_stall_raw;

  // The IDLE term must be combinational: the pipeline has to freeze in the
  // very cycle the request appears, before any register can react.
  assign w_stall_raw = ((r_state == ST_IDLE) && (l1_req || l2_req)) ||
                       (r_state == ST_L1_WAIT) ||
                       (r_state == ST_L2_WAIT);

  // Gate with reset so requests present during reset do not freeze the pipe.
  assign stall     = reset && w_stall_raw;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign l1_rdata  = r_l1_rdata;
  assign l2_rdata  = r_l2_rdata;

  // ---------------------------------------------------------------------------
  // Optional conflict statistics
  // ---------------------------------------------------------------------------
`ifdef DMEM_ARB_STATS_EN
  logic w_conflict_inc;

  // Counts IDLE->L1_WAIT steps that also carry a lane 2 access.
  assign w_conflict_inc = (r_state == ST_IDLE) && l1_req && l2_req;

  dmem_arb_stats #(
    .CNT_W (CNT_W)
  ) u_stats (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_conflict_inc),
    .o_cnt (conflict_cnt)
  );
`else
  assign conflict_cnt = '0;
`endif

endmodule : dmem_dual_lane_arbiter

// File: tb/tb_dmem_dual_lane_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_dual_lane_arbiter
//   Directed bench for dmem_dual_lane_arbiter. A behavioural memory answers
//   the req/ack handshake with a programmable ack delay; expected memory
//   transactions are queued when a step is driven and popped on each ack.
// -----------------------------------------------------------------------------
module tb_dmem_dual_lane_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int CNT_W = 2;

`ifdef DMEM_ARB_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             l1_req = 1'b0, l1_we = 1'b0;
  logic [AW-1:0]    l1_addr = '0;
  logic [DW-1:0]    l1_wdata = '0;
  logic             l2_req = 1'b0, l2_we = 1'b0;
  logic [AW-1:0]    l2_addr = '0;
  logic [DW-1:0]    l2_wdata = '0;
  logic [DW-1:0]    l1_rdata, l2_rdata;
  logic             stall, mem_req, mem_we;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic             mem_ack = 1'b0;
  logic [DW-1:0]    mem_rdata = '0;
  logic [CNT_W-1:0] conflict_cnt;

  int n_vec = 0;
  int n_err = 0;

  txn_t          exp_q[$];
  logic [DW-1:0] mem[logic [AW-1:0]];
  int            ack_delay = 0;
  bit            stray_ack = 1'b0;
  int            wait_cnt = 0;
  logic          seen_we;
  logic [AW-1:0] seen_addr;
  logic [DW-1:0] seen_wdata;

  always #5 clk = ~clk;

  dmem_dual_lane_arbiter #(
    .AW    (AW),
    .DW    (DW),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .l1_req       (l1_req),
    .l1_we        (l1_we),
    .l1_addr      (l1_addr),
    .l1_wdata     (l1_wdata),
    .l2_req       (l2_req),
    .l2_we        (l2_we),
    .l2_addr      (l2_addr),
    .l2_wdata     (l2_wdata),
    .l1_rdata     (l1_rdata),
    .l2_rdata     (l2_rdata),
    .stall        (stall),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .conflict_cnt (conflict_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory model: reacts on the falling edge so the DUT sees ack/rdata at the
  // next rising edge. Commits writes and checks the scoreboard on each ack.
  always @(negedge clk) begin
    txn_t e;
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (!rst_n) begin
      wait_cnt = 0;
    end else if (mem_req) begin
      if (wait_cnt == 0) begin
        seen_we    = mem_we;
        seen_addr  = mem_addr;
        seen_wdata = mem_wdata;
      end else begin
        check("hold_we",    32'(mem_we),  32'(seen_we));
        check("hold_addr",  mem_addr,     seen_addr);
        check("hold_wdata", mem_wdata,    seen_wdata);
      end
      if (wait_cnt >= ack_delay) begin
        mem_ack  = 1'b1;
        wait_cnt = 0;
        check("sb_has_txn", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("txn_we",   32'(mem_we), 32'(e.we));
          check("txn_addr", mem_addr,    e.addr);
          if (e.we) begin
            check("txn_wdata", mem_wdata, e.wdata);
          end
        end
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
        end else begin
          mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : '0;
        end
        $display("mem txn: we=%0d addr=%h wdata=%h rdata=%h",
                 mem_we, mem_addr, mem_wdata, mem_rdata);
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
      if (stray_ack) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
      end
    end
  end

  // One pipeline step: drive both lanes, wait for DONE (stall low), check.
  task automatic run_op(input string tag,
                        input logic a_req, input logic a_we,
                        input logic [31:0] a_addr, input logic [31:0] a_wd,
                        input logic b_req, input logic b_we,
                        input logic [31:0] b_addr, input logic [31:0] b_wd,
                        input int e_stall, input int e_reqc,
                        input logic [31:0] e_l1, input logic [31:0] e_l2);
    int sc;
    int rc;
    bit done;
    sc = 0;
    rc = 0;
    done = 1'b0;
    @(posedge clk);
    #1;
    if (a_req) exp_q.push_back('{a_we, a_addr, a_wd});
    if (b_req) exp_q.push_back('{b_we, b_addr, b_wd});
    l1_req = a_req; l1_we = a_we; l1_addr = a_addr; l1_wdata = a_wd;
    l2_req = b_req; l2_we = b_we; l2_addr = b_addr; l2_wdata = b_wd;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (mem_req) rc++;
      if (stall) sc++;
      else done = 1'b1;
    end
    check({tag, "_done"},     32'(done), 32'd1);
    check({tag, "_stall"},    32'(sc),   32'(e_stall));
    check({tag, "_reqcyc"},   32'(rc),   32'(e_reqc));
    check({tag, "_l1_rdata"}, l1_rdata,  e_l1);
    check({tag, "_l2_rdata"}, l2_rdata,  e_l2);
    check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    $display("step %s: stall=%0d reqcyc=%0d l1=%h l2=%h cnt=%0d",
             tag, sc, rc, l1_rdata, l2_rdata, conflict_cnt);
    @(posedge clk);
    #1;
    l1_req = 1'b0;
    l2_req = 1'b0;
    @(negedge clk);
    check({tag, "_idle_stall"}, 32'(stall), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_cnt;
    mem[32'h10] = 32'hDEAD_BEEF;
    mem[32'h30] = 32'hCAFE_F00D;

    // Reset state, with a request present to show stall is gated.
    l1_req = 1'b1;
    #2;
    check("rst_stall",     32'(stall),   32'd0);
    check("rst_mem_req",   32'(mem_req), 32'd0);
    check("rst_mem_we",    32'(mem_we),  32'd0);
    check("rst_mem_addr",  mem_addr,     32'd0);
    check("rst_mem_wdata", mem_wdata,    32'd0);
    check("rst_l1_rdata",  l1_rdata,     32'd0);
    check("rst_l2_rdata",  l2_rdata,     32'd0);
    check("rst_cnt",       32'(conflict_cnt), 32'd0);
    @(negedge clk);
    #1;
    l1_req = 1'b0;
    rst_n  = 1'b1;

    // 1. Idle for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_stall",   32'(stall),   32'd0);
      check("idle_mem_req", 32'(mem_req), 32'd0);
    end

    // 2. Lane 1 load only, immediate ack.
    ack_delay = 0;
    run_op("l1_load", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
           2, 1, 32'hDEAD_BEEF, 32'h0);

    // Stray acks while idle must not disturb anything.
    stray_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stray_mem_req", 32'(mem_req), 32'd0);
      check("stray_stall",   32'(stall),   32'd0);
    end
    stray_ack = 1'b0;
    @(negedge clk);
    check("stray_l1_rdata", l1_rdata, 32'hDEAD_BEEF);
    check("stray_l2_rdata", l2_rdata, 32'h0);

    // 3. Lane 1 store then lane 2 load, same address.
    run_op("st_ld", 1'b1, 1'b1, 32'h20, 32'h11, 1'b1, 1'b0, 32'h20, 32'h0,
           4, 2, 32'hDEAD_BEEF, 32'h11);
    check("st_ld_cnt", 32'(conflict_cnt), STATS_ON ? 32'd1 : 32'd0);

    // 4. Lane 2 load only, ack after three waiting cycles.
    ack_delay = 3;
    run_op("l2_slow", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0,
           5, 4, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    ack_delay = 0;

    // Two stores to one address: lane 2's value must win.
    run_op("st_st", 1'b1, 1'b1, 32'h40, 32'hAAAA, 1'b1, 1'b1, 32'h40, 32'hBBBB,
           4, 2, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    check("st_st_mem", mem[32'h40], 32'hBBBB);
    check("st_st_cnt", 32'(conflict_cnt), STATS_ON ? 32'd2 : 32'd0);

    // 5. Reset while lane 2 waits for a slow ack.
    ack_delay = 10;
    @(posedge clk);
    #1;
    exp_q.push_back('{1'b0, 32'h30, 32'h0});
    l2_req = 1'b1; l2_we = 1'b0; l2_addr = 32'h30;
    repeat (3) @(negedge clk);
    check("pre_rst_mem_req", 32'(mem_req), 32'd1);
    check("pre_rst_stall",   32'(stall),   32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_mem_req",  32'(mem_req), 32'd0);
    check("mid_rst_stall",    32'(stall),   32'd0);
    check("mid_rst_l1_rdata", l1_rdata,     32'd0);
    check("mid_rst_l2_rdata", l2_rdata,     32'd0);
    check("mid_rst_cnt",      32'(conflict_cnt), 32'd0);
    @(posedge clk);
    #1;
    l2_req = 1'b0;
    exp_q.delete();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    ack_delay = 0;
    run_op("post_rst", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
           2, 1, 32'hDEAD_BEEF, 32'h0);

    // 6. Five dual-lane loads; counter saturates at 3 with CNT_W=2.
    for (int k = 1; k <= 5; k++) begin
      run_op("dual_ld", 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0,
             4, 2, 32'hDEAD_BEEF, 32'hCAFE_F00D);
      exp_cnt = STATS_ON ? ((k > 3) ? 32'd3 : 32'(k)) : 32'd0;
      check("dual_cnt", 32'(conflict_cnt), exp_cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_dmem_dual_lane_arbiter
